// File: rtl/cache_miss_controller.sv
// cache_miss_controller: L1 2-way cache hit/writeback/fill sequencing FSM.
// Define CACHE_PERF_CNT_EN to add hit_count/miss_count outputs.
module cache_miss_controller #(
   parameter int PMEM_TIMEOUT = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        hit,
   input  logic        replace,
   input  logic        dirty,
   input  logic        update_way,
   input  logic        pmem_resp,
   output logic        mem_resp,
   output logic        pmem_read,
   output logic        pmem_write,
   output logic        way_sel,
   output logic        load_data,
   output logic        load_tag,
   output logic        load_valid,
   output logic        set_dirty,
   output logic        clr_dirty,
   output logic        load_lru,
   output logic        data_src,
   output logic        addr_src,
   output logic        pmem_err
`ifdef CACHE_PERF_CNT_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);
   localparam int CW = PMEM_TIMEOUT > 0 ? $clog2(PMEM_TIMEOUT + 1) : 1;
   typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, FILL} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   logic req, wait_mem;
   assign req = mem_read | mem_write;
   assign wait_mem = (state == WRITEBACK) || (state == FILL);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         way_sel  <= 1'b0;
         pmem_err <= 1'b0;
         cnt      <= '0;
      end else begin
         // counter saturates at the limit so the flag logic never sees a wrap
         if (wait_mem && !pmem_resp) begin
            if (cnt != CW'(PMEM_TIMEOUT)) cnt <= cnt + 1'b1;
            if (PMEM_TIMEOUT != 0 && cnt == CW'(PMEM_TIMEOUT - 1)) pmem_err <= 1'b1;
         end
         case (state)
            IDLE: if (req) state <= CHECK;
            CHECK: begin
               if (!req || hit) state <= IDLE;
               else begin
                  way_sel <= update_way;
                  cnt     <= '0;
                  state   <= (dirty && replace) ? WRITEBACK : FILL;
               end
            end
            WRITEBACK: if (pmem_resp) begin
               cnt   <= '0;
               state <= FILL;
            end
            FILL: if (pmem_resp) state <= CHECK;
            default: state <= IDLE;
         endcase
      end
   end
   always_comb begin
      mem_resp   = 1'b0;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      load_data  = 1'b0;
      load_tag   = 1'b0;
      load_valid = 1'b0;
      set_dirty  = 1'b0;
      clr_dirty  = 1'b0;
      load_lru   = 1'b0;
      data_src   = 1'b0;
      addr_src   = 1'b0;
      case (state)
         CHECK: if (req && hit) begin
            mem_resp  = 1'b1;
            load_lru  = 1'b1;
            load_data = mem_write;
            set_dirty = mem_write;
         end
         WRITEBACK: begin
            pmem_write = 1'b1;
            addr_src   = 1'b1;
         end
         FILL: begin
            pmem_read = 1'b1;
            {load_data, load_tag, load_valid, clr_dirty, data_src} = {5{pmem_resp}};
         end
         default: ;
      endcase
   end
`ifdef CACHE_PERF_CNT_EN
   logic refill;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         refill     <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         refill <= (state == FILL) && pmem_resp;
         if (state == CHECK && hit && !refill) hit_count <= hit_count + 1'b1;
         if (state == CHECK && req && !hit) miss_count <= miss_count + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_cache_miss_controller.sv
// tb_cache_miss_controller: table-driven cycle vectors plus timeout/async-reset sequences.
module tb_cache_miss_controller;
   localparam logic [6:0] RD = 7'h40, WR = 7'h20, HT = 7'h10, RP = 7'h08,
                          DT = 7'h04, UW = 7'h02, PS = 7'h01;
   localparam logic [12:0] MR = 13'h1000, PR = 13'h0800, PW = 13'h0400, WS = 13'h0200,
                           LD = 13'h0100, LT = 13'h0080, LV = 13'h0040, SD = 13'h0020,
                           CD = 13'h0010, LL = 13'h0008, DS = 13'h0004, AS = 13'h0002,
                           ER = 13'h0001;
   localparam logic [12:0] FILL_DONE = PR | LD | LT | LV | CD | DS;
   typedef struct {
      logic [6:0]  in;
      logic [12:0] exp;
   } vec_t;
   vec_t tbl[$];
   logic clk = 1'b0, rst_n = 1'b0;
   logic [6:0] m_in, t_in;
   wire [12:0] m_out, t_out;
   int n_vec = 0, n_err = 0;
   always #5 clk = ~clk;
`ifdef CACHE_PERF_CNT_EN
   wire [31:0] m_hc, m_mc, t_hc, t_mc;
`endif
   cache_miss_controller m_dut (
      .clk(clk), .rst_n(rst_n),
      .mem_read(m_in[6]), .mem_write(m_in[5]), .hit(m_in[4]), .replace(m_in[3]),
      .dirty(m_in[2]), .update_way(m_in[1]), .pmem_resp(m_in[0]),
      .mem_resp(m_out[12]), .pmem_read(m_out[11]), .pmem_write(m_out[10]), .way_sel(m_out[9]),
      .load_data(m_out[8]), .load_tag(m_out[7]), .load_valid(m_out[6]), .set_dirty(m_out[5]),
      .clr_dirty(m_out[4]), .load_lru(m_out[3]), .data_src(m_out[2]), .addr_src(m_out[1]),
      .pmem_err(m_out[0])
`ifdef CACHE_PERF_CNT_EN
      , .hit_count(m_hc), .miss_count(m_mc)
`endif
   );
   cache_miss_controller #(.PMEM_TIMEOUT(8)) t_dut (
      .clk(clk), .rst_n(rst_n),
      .mem_read(t_in[6]), .mem_write(t_in[5]), .hit(t_in[4]), .replace(t_in[3]),
      .dirty(t_in[2]), .update_way(t_in[1]), .pmem_resp(t_in[0]),
      .mem_resp(t_out[12]), .pmem_read(t_out[11]), .pmem_write(t_out[10]), .way_sel(t_out[9]),
      .load_data(t_out[8]), .load_tag(t_out[7]), .load_valid(t_out[6]), .set_dirty(t_out[5]),
      .clr_dirty(t_out[4]), .load_lru(t_out[3]), .data_src(t_out[2]), .addr_src(t_out[1]),
      .pmem_err(t_out[0])
`ifdef CACHE_PERF_CNT_EN
      , .hit_count(t_hc), .miss_count(t_mc)
`endif
   );
   task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %013b expected %013b", name, act, exp);
      end
   endtask
   function automatic void v(input logic [6:0] i, input logic [12:0] e);
      tbl.push_back('{i, e});
   endfunction
   initial begin
      m_in = '0;
      t_in = '0;
      v(0, 0);
      v(RD, 0);                 v(RD | HT, MR | LL);        v(0, 0);
      v(WR, 0);                 v(WR | HT, MR | LL | LD | SD);
      v(RD, 0);                 v(RD | UW, 0);
      repeat (4) v(RD, PR | WS);
      v(RD | PS, FILL_DONE | WS); v(RD | HT, MR | LL | WS);   v(0, WS);
      v(WR, WS);                v(WR | RP | DT, WS);
      v(WR | UW, PW | AS);      v(WR, PW | AS);             v(WR | UW | PS, PW | AS);
      v(WR | UW, PR);           v(WR | PS, FILL_DONE);      v(WR | HT, MR | LL | LD | SD);
      v(RD | WR, 0);            v(RD | WR | HT, MR | LL | LD | SD);
      v(RD | UW, 0);            v(RD | DT | UW, 0);         v(RD | PS, FILL_DONE | WS);
      v(HT, WS);                v(PS, WS);
      v(RD, WS);                v(RD | PS | HT, MR | LL | WS); v(0, WS);
      v(WR, WS);                v(WR | RP | DT, WS);
      v(0, PW | AS);            v(PS, PW | AS);             v(PS, FILL_DONE);
      v(0, 0);                  v(0, 0);
      repeat (3) @(negedge clk);
      #1;
      chk("reset_main", m_out, 0);
      chk("reset_tmo", t_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      foreach (tbl[i]) begin
         m_in = tbl[i].in;
         #1 chk($sformatf("vec%0d", i), m_out, tbl[i].exp);
         @(negedge clk);
      end
      t_in = RD;
      #1 chk("tmo_idle", t_out, 0);
      @(negedge clk);
      #1 chk("tmo_check_miss", t_out, 0);
      @(negedge clk);
      // the flag is visible once 8 full FILL cycles have elapsed
      for (int k = 1; k <= 20; k++) begin
         #1 chk($sformatf("tmo_fill%0d", k), t_out, PR | (k > 8 ? ER : 13'h0));
         @(negedge clk);
      end
      t_in = RD | PS;
      #1 chk("tmo_fill_done", t_out, FILL_DONE | ER);
      @(negedge clk);
      t_in = RD | HT;
      #1 chk("tmo_recheck_hit", t_out, MR | LL | ER);
      @(negedge clk);
      t_in = 0;
      #1 chk("tmo_err_sticky", t_out, ER);
      @(negedge clk);
      t_in = RD;
      @(negedge clk);
      t_in = RD | UW;
      @(negedge clk);
      t_in = RD;
      #1 chk("tmo_second_fill", t_out, PR | WS | ER);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_tmo", t_out, 0);
      chk("async_rst_main", m_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      t_in = 0;
      #1 chk("post_rst_idle", t_out, 0);
      @(negedge clk);
      t_in = RD;
      @(negedge clk);
      t_in = RD | HT;
      #1 chk("post_rst_hit", t_out, MR | LL);
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
